muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 206 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: RISC-V M-extension style multiply/divide unit.
// Multiplies take one compute cycle; divides use a restoring radix-2
// iteration (one quotient bit per cycle) followed by a sign-fix cycle.
// Divide-by-zero and signed overflow bypass the iteration entirely.
// Build option: define MULDIV_DIV_EN to include the divider. Without it,
// divide requests complete in one cycle with a zero result.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state_q;
    logic [1:0]        mul_op_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [XLEN-1:0]   result_q;
    logic              out_valid_q;

    logic              a_sx;
    logic              b_sx;
    logic [2*XLEN-1:0] prod_d;
    logic [XLEN-1:0]   mul_res_d;

    // Multiplier: sign-extend each operand to 2*XLEN as the op requires,
    // then pick the low half for MUL and the high half otherwise.
    always_comb begin
        a_sx      = a_q[XLEN-1] & (mul_op_q != 2'b11);
        b_sx      = b_q[XLEN-1] & (mul_op_q == 2'b01);
        prod_d    = {{XLEN{a_sx}}, a_q} * {{XLEN{b_sx}}, b_q};
        mul_res_d = (mul_op_q == 2'b00) ? prod_d[XLEN-1:0] : prod_d[2*XLEN-1:XLEN];
    end

`ifdef MULDIV_DIV_EN
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic            is_rem_q;
    logic            quo_neg_q;
    logic            rem_neg_q;

    logic            in_signed;
    logic            in_is_rem;
    logic            op1_neg;
    logic            op2_neg;
    logic [XLEN-1:0] op1_mag;
    logic [XLEN-1:0] op2_mag;
    logic            div_special;
    logic [XLEN-1:0] special_res_d;
    logic [XLEN:0]   rem_shift_d;
    logic [XLEN:0]   rem_sub_d;
    logic [XLEN-1:0] rem_step_d;
    logic [XLEN-1:0] quo_step_d;
    logic [XLEN-1:0] div_res_d;

    // Divider datapath: request decode, special cases, one restoring step,
    // and the final sign correction of quotient / remainder.
    always_comb begin
        in_signed   = ~op[0];
        in_is_rem   = op[1];
        op1_neg     = in_signed & op1[XLEN-1];
        op2_neg     = in_signed & op2[XLEN-1];
        op1_mag     = op1_neg ? -op1 : op1;
        op2_mag     = op2_neg ? -op2 : op2;
        div_special = 1'b0;
        special_res_d = '0;
        if (op2 == '0) begin
            div_special   = 1'b1;
            special_res_d = in_is_rem ? op1 : '1;
        end else if (in_signed && (op1 == MOST_NEG) && (op2 == '1)) begin
            div_special   = 1'b1;
            special_res_d = in_is_rem ? '0 : op1;
        end
        // A clear borrow bit means the shifted remainder covers the divisor.
        rem_shift_d = {rem_q, quo_q[XLEN-1]};
        rem_sub_d   = rem_shift_d - {1'b0, dvs_q};
        rem_step_d  = rem_sub_d[XLEN] ? rem_shift_d[XLEN-1:0] : rem_sub_d[XLEN-1:0];
        quo_step_d  = {quo_q[XLEN-2:0], ~rem_sub_d[XLEN]};
        if (is_rem_q) begin
            div_res_d = rem_neg_q ? -rem_q : rem_q;
        end else begin
            div_res_d = quo_neg_q ? -quo_q : quo_q;
        end
    end
`endif

    // Control FSM with registered result and valid; flush aborts any state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mul_op_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
`ifdef MULDIV_DIV_EN
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            is_rem_q    <= 1'b0;
            quo_neg_q   <= 1'b0;
            rem_neg_q   <= 1'b0;
`endif
        end else if (flush) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            out_valid_q <= 1'b0;
`ifdef MULDIV_DIV_EN
            cnt_q       <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        mul_op_q <= op[1:0];
                        a_q      <= op1;
                        b_q      <= op2;
                        if (!op[2]) begin
                            state_q <= ST_MUL;
                        end else begin
`ifdef MULDIV_DIV_EN
                            if (div_special) begin
                                result_q    <= special_res_d;
                                out_valid_q <= 1'b1;
                                state_q     <= ST_DONE;
                            end else begin
                                cnt_q     <= '0;
                                rem_q     <= '0;
                                quo_q     <= op1_mag;
                                dvs_q     <= op2_mag;
                                is_rem_q  <= in_is_rem;
                                quo_neg_q <= op1_neg ^ op2_neg;
                                rem_neg_q <= op1_neg;
                                state_q   <= ST_DIV;
                            end
`else
                            result_q    <= '0;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
`endif
                        end
                    end
                end
                ST_MUL: begin
                    result_q    <= mul_res_d;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
`ifdef MULDIV_DIV_EN
                ST_DIV: begin
                    if (cnt_q == CNT_LAST) begin
                        result_q    <= div_res_d;
                        out_valid_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= ST_DONE;
                    end else begin
                        rem_q <= rem_step_d;
                        quo_q <= quo_step_d;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
`endif
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven vectors with a result/latency scoreboard,
// plus hand-written sequences for back-pressure, flush and reset.
// Adapts to the build: divide vectors when MULDIV_DIV_EN is defined,
// divider-less behaviour otherwise.
module tb_muldiv_unit;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .op1(op1), .op2(op2), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string what, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", what, act, req);
        end
    endtask

    // Drive one request, wait (bounded) for acceptance, record the expectation.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input int el);
        int guard = 0;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1; op = o; op1 = a; op2 = b;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        e.res = er; e.lat = el;
        exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        op1 = $urandom;
        op2 = $urandom;
    endtask

    // Called on the first negedge after acceptance; counts cycles to out_valid.
    task automatic wait_out(input string what);
        int lat = 1;
        exp_t e;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk({what, "_valid"}, {31'b0, out_valid}, 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({what, "_result"}, result, e.res);
            chk({what, "_latency"}, lat, e.lat);
        end else begin
            chk({what, "_scoreboard"}, 32'd0, 32'd1);
        end
        $display("txn %s: result=%h latency=%0d", what, result, lat);
    endtask

    task automatic collect(input string what);
        wait_out(what);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

`ifdef MULDIV_DIV_EN
    localparam int NV = 15;
`else
    localparam int NV = 7;
`endif
    vec_t vecs[NV];

    initial begin
        int seen;
        // MUL/MULH/MULHSU/MULHU, then divides
        vecs[0] = '{3'b000, 32'd3,         32'hFFFFFFFE, 32'hFFFFFFFA, 2};
        vecs[1] = '{3'b001, 32'h80000000,  32'h80000000, 32'h40000000, 2};
        vecs[2] = '{3'b010, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF, 2};
        vecs[3] = '{3'b011, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 2};
        vecs[4] = '{3'b000, 32'h12345678,  32'h00000010, 32'h23456780, 2};
`ifdef MULDIV_DIV_EN
        vecs[5]  = '{3'b101, 32'd100,        32'd7,        32'd14,        34};
        vecs[6]  = '{3'b110, 32'hFFFFFF9C,   32'd7,        32'hFFFFFFFE,  34};
        vecs[7]  = '{3'b100, 32'hFFFFFF9C,   32'd7,        32'hFFFFFFF2,  34};
        vecs[8]  = '{3'b111, 32'd100,        32'd7,        32'd2,         34};
        vecs[9]  = '{3'b100, 32'd5,          32'd0,        32'hFFFFFFFF,  1};
        vecs[10] = '{3'b111, 32'd5,          32'd0,        32'd5,         1};
        vecs[11] = '{3'b100, 32'h80000000,   32'hFFFFFFFF, 32'h80000000,  1};
        vecs[12] = '{3'b110, 32'h80000000,   32'hFFFFFFFF, 32'd0,         1};
        vecs[13] = '{3'b100, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD,  34};
        vecs[14] = '{3'b110, 32'd7,          32'hFFFFFFFE, 32'd1,         34};
`else
        vecs[5]  = '{3'b100, 32'd100,        32'd7,        32'd0,         1};
        vecs[6]  = '{3'b111, 32'd5,          32'd0,        32'd0,         1};
`endif

        rst = 1'b1; in_valid = 1'b0; op = '0; op1 = '0; op2 = '0;
        flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);

        for (int i = 0; i < NV; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);
            collect($sformatf("vec%0d", i));
        end

        // Back-pressure: result held in DONE while out_ready is low.
        issue(3'b000, 32'd3, 32'd5, 32'd15, 2);
        wait_out("hold_first");
        in_valid = 1'b1; op = 3'b000; op1 = 32'd2; op2 = 32'd2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'b0, out_valid}, 32'd1);
            chk("hold_result", result, 32'd15);
            chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_in_ready", {31'b0, in_ready}, 32'd1);
        chk("release_busy", {31'b0, busy}, 32'd0);
        chk("release_out_valid", {31'b0, out_valid}, 32'd0);
        begin
            exp_t e;
            e.res = 32'd4; e.lat = 2;
            exp_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("next_accept_busy", {31'b0, busy}, 32'd1);
        collect("mul_after_hold");

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        in_valid = 1'b1; op = 3'b000; op1 = 32'd7; op2 = 32'd9;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mul_busy_before_rst", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_async_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_async_result", result, 32'd0);
        chk("rst_async_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_release_in_ready", {31'b0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("rst_no_out_valid", seen, 32'd0);
        $display("txn rst_mid_mul: out_valid cycles=%0d", seen);

        // Flush of an in-flight operation.
        @(negedge clk);
`ifdef MULDIV_DIV_EN
        in_valid = 1'b1; op = 3'b101; op1 = 32'd100; op2 = 32'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
`else
        in_valid = 1'b1; op = 3'b000; op1 = 32'd100; op2 = 32'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
`endif
        chk("flush_busy_before", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy_after", {31'b0, busy}, 32'd0);
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("flush_no_out_valid", seen, 32'd0);
        $display("txn flush_in_flight: out_valid cycles=%0d", seen);

        // Flush while idle blocks acceptance.
        in_valid = 1'b1; flush = 1'b1; op = 3'b000; op1 = 32'd1; op2 = 32'd1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_blocks", {31'b0, busy}, 32'd0);
        $display("txn flush_idle: busy=%0b", busy);

        issue(3'b000, 32'd6, 32'd7, 32'd42, 2);
        collect("mul_after_flush");

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
